// File: rtl/xlib_avalon_bus_arb.sv
// N-port Avalon-MM burst arbiter: one registered grant (1 cycle s_val->m_val, 1 idle bubble per burst), in-order read-return routing FIFO.
// Backpressure: m_rdy passes straight to the granted port only; reads wait while the return FIFO is full, writes never do.

module xlib_fifo #(
  parameter int W  = 8,
  parameter int LD = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);
  localparam int D = 1 << LD;

  logic [W-1:0]  mem [D];
  logic [LD-1:0] wp, rp;
  logic [LD:0]   cnt;
  logic          do_wr, do_rd;

  assign full   = (cnt == (LD+1)'(D));
  assign empty  = (cnt == '0);
  assign rd_dat = mem[rp];
  assign do_wr  = wr_vld & ~full;
  assign do_rd  = rd_rdy & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_wr) wp <= wp + LD'(1);
      if (do_rd) rp <= rp + LD'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + (LD+1)'(1);
        2'b01:   cnt <= cnt - (LD+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wr_dat;
  end
endmodule

module xlib_avalon_bus_arb #(
  parameter int N    = 4,
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int BL   = 4,
  parameter int FW   = 3,
  parameter int MODE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    s_val,
  output logic [N-1:0]    s_rdy,
  input  logic [N-1:0]    s_wr,
  input  logic [N*BL-1:0] s_len,
  input  logic [N*AW-1:0] s_addr,
  input  logic [N*DW-1:0] s_wdata,
  output logic [N*DW-1:0] s_rdata,
  output logic [N-1:0]    s_rdval,
  input  logic            m_rdy,
  output logic            m_val,
  output logic            m_wr,
  output logic [BL-1:0]   m_len,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_rdval,
  output logic            err_orphan
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, WBURST} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    grant, grant_nxt, last_grant, last_grant_nxt;
  logic [PW-1:0]    fp_win, rr_win, head_port;
  logic [BL-1:0]    wcnt, wcnt_nxt, rcnt, cur_len, eff_len, head_len;
  logic [N-1:0]     elig;
  logic             any_elig, rr_found, cur_val, cur_wr;
  logic             fifo_full, fifo_empty, push, pop, rd_beat;
  logic [PW+BL-1:0] push_dat, head;

  always_comb begin
    int idx;
    idx      = 0;
    elig     = s_val & (s_wr | {N{~fifo_full}});
    any_elig = |elig;
    fp_win   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) fp_win = PW'(i);
    end
    // Round-robin search starts just past the last winner and wraps.
    rr_win   = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!rr_found && elig[idx]) begin
        rr_win   = PW'(idx);
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    cur_val = s_val[grant];
    cur_wr  = s_wr[grant];
    cur_len = s_len[grant*BL +: BL];
    eff_len = (cur_len == '0) ? BL'(1) : cur_len;
  end

  assign push_dat = {grant, eff_len};

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    wcnt_nxt       = wcnt;
    push           = 1'b0;
    s_rdy          = '0;
    m_val          = 1'b0;
    m_wr           = 1'b0;
    m_len          = '0;
    m_addr         = '0;
    m_wdata        = '0;
    case (state)
      IDLE: begin
        if (any_elig) begin
          grant_nxt      = (MODE == 0) ? fp_win : rr_win;
          last_grant_nxt = grant_nxt;
          state_nxt      = GRANT;
        end
      end
      GRANT, WBURST: begin
        m_val        = cur_val;
        m_wr         = cur_wr;
        m_len        = cur_len;
        m_addr       = s_addr[grant*AW +: AW];
        m_wdata      = s_wdata[grant*DW +: DW];
        s_rdy[grant] = m_rdy;
        if (cur_val && m_rdy) begin
          if (state == GRANT) begin
            if (!cur_wr) begin
              push      = 1'b1;
              state_nxt = IDLE;
            end else if (eff_len == BL'(1)) begin
              state_nxt = IDLE;
            end else begin
              wcnt_nxt  = eff_len - BL'(1);
              state_nxt = WBURST;
            end
          end else if (wcnt == BL'(1)) begin
            wcnt_nxt  = '0;
            state_nxt = IDLE;
          end else begin
            wcnt_nxt = wcnt - BL'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  xlib_fifo #(.W(PW + BL), .LD(FW)) u_rd_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (push),
    .wr_dat (push_dat),
    .rd_rdy (pop),
    .rd_dat (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Read data returns in command order, so the FIFO head names the owner of every beat.
  assign head_port = head[BL +: PW];
  assign head_len  = head[BL-1:0];
  assign rd_beat   = m_rdval & ~fifo_empty;
  assign pop       = rd_beat & (rcnt == head_len - BL'(1));
  assign s_rdata   = {N{m_rdata}};

  always_comb begin
    s_rdval = '0;
    if (rd_beat) s_rdval[head_port] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= PW'(N - 1);
      wcnt       <= '0;
      rcnt       <= '0;
      err_orphan <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      wcnt       <= wcnt_nxt;
      if (rd_beat) rcnt <= pop ? '0 : rcnt + BL'(1);
      if (m_rdval && fifo_empty) err_orphan <= 1'b1;
    end
  end
endmodule

// File: tb/tb_xlib_avalon_bus_arb.sv
// Two arbiters (fixed priority / FIFO depth 2, round-robin / depth 4) driven by random clients,
// each compared every cycle against a transaction-level model of bus ownership and read return.
module tb_xlib_avalon_bus_arb;
  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int BL   = 4;
  localparam int NCYC = 4000;

  logic clk, rst;

  logic [N-1:0]    s_val   [2];
  logic [N-1:0]    s_wr    [2];
  logic [N*BL-1:0] s_len   [2];
  logic [N*AW-1:0] s_addr  [2];
  logic [N*DW-1:0] s_wdata [2];
  logic            m_rdy   [2];
  logic            m_rdval [2];
  logic [DW-1:0]   m_rdata [2];

  wire [N-1:0]    s_rdy      [2];
  wire [N-1:0]    s_rdval    [2];
  wire [N*DW-1:0] s_rdata    [2];
  wire            m_val      [2];
  wire            m_wr       [2];
  wire [BL-1:0]   m_len      [2];
  wire [AW-1:0]   m_addr     [2];
  wire [DW-1:0]   m_wdata    [2];
  wire            err_orphan [2];

  xlib_avalon_bus_arb #(.N(N), .DW(DW), .AW(AW), .BL(BL), .FW(1), .MODE(0)) u_fp (
    .clk(clk), .rst(rst),
    .s_val(s_val[0]), .s_rdy(s_rdy[0]), .s_wr(s_wr[0]), .s_len(s_len[0]),
    .s_addr(s_addr[0]), .s_wdata(s_wdata[0]), .s_rdata(s_rdata[0]), .s_rdval(s_rdval[0]),
    .m_rdy(m_rdy[0]), .m_val(m_val[0]), .m_wr(m_wr[0]), .m_len(m_len[0]),
    .m_addr(m_addr[0]), .m_wdata(m_wdata[0]), .m_rdata(m_rdata[0]), .m_rdval(m_rdval[0]),
    .err_orphan(err_orphan[0])
  );

  xlib_avalon_bus_arb #(.N(N), .DW(DW), .AW(AW), .BL(BL), .FW(2), .MODE(1)) u_rr (
    .clk(clk), .rst(rst),
    .s_val(s_val[1]), .s_rdy(s_rdy[1]), .s_wr(s_wr[1]), .s_len(s_len[1]),
    .s_addr(s_addr[1]), .s_wdata(s_wdata[1]), .s_rdata(s_rdata[1]), .s_rdval(s_rdval[1]),
    .m_rdy(m_rdy[1]), .m_val(m_val[1]), .m_wr(m_wr[1]), .m_len(m_len[1]),
    .m_addr(m_addr[1]), .m_wdata(m_wdata[1]), .m_rdata(m_rdata[1]), .m_rdval(m_rdval[1]),
    .err_orphan(err_orphan[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // owner < 0: bus free (arbitration cycle); beats_left < 0: command not yet accepted.
  int owner [2], beats_left [2], rr_last [2], rq_n [2], beats_done [2];
  int rq_p [2][8], rq_l [2][8];
  bit orphan [2];
  int depth [2] = '{2, 4};
  int mode  [2] = '{0, 1};

  bit            pend   [2][N];
  bit            pwr    [2][N];
  int            plen   [2][N];
  int            pbeats [2][N];
  logic [AW-1:0] paddr  [2][N];

  logic          e_val [2], e_wr [2];
  logic [BL-1:0] e_len [2];
  logic [AW-1:0] e_addr [2];
  logic [DW-1:0] e_wdata [2];
  logic [N-1:0]  e_rdy [2], e_rdval [2];

  bit no_new, rdv_hot, force_orphan;
  int next_rst;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      owner[d] = -1; beats_left[d] = -1; rr_last[d] = N - 1;
      rq_n[d] = 0; beats_done[d] = 0; orphan[d] = 1'b0;
      for (int i = 0; i < N; i++) pend[d][i] = 1'b0;
    end
  endtask

  task automatic reset_check(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d m_val", tag, d), 128'(m_val[d]), 128'(0));
      chk($sformatf("%s d%0d m_wr", tag, d), 128'(m_wr[d]), 128'(0));
      chk($sformatf("%s d%0d m_len", tag, d), 128'(m_len[d]), 128'(0));
      chk($sformatf("%s d%0d m_addr", tag, d), 128'(m_addr[d]), 128'(0));
      chk($sformatf("%s d%0d m_wdata", tag, d), 128'(m_wdata[d]), 128'(0));
      chk($sformatf("%s d%0d s_rdy", tag, d), 128'(s_rdy[d]), 128'(0));
      chk($sformatf("%s d%0d s_rdval", tag, d), 128'(s_rdval[d]), 128'(0));
      chk($sformatf("%s d%0d err_orphan", tag, d), 128'(err_orphan[d]), 128'(0));
    end
  endtask

  task automatic drive(input int d);
    for (int i = 0; i < N; i++) begin
      if (!pend[d][i] && !no_new && $urandom_range(0, 2) == 0) begin
        pend[d][i]   = 1'b1;
        pwr[d][i]    = 1'($urandom_range(0, 1));
        plen[d][i]   = int'($urandom_range(0, 5));
        paddr[d][i]  = $urandom;
        pbeats[d][i] = 0;
      end
      s_val[d][i] = pend[d][i];
      s_wr[d][i]  = pend[d][i] ? pwr[d][i] : 1'($urandom_range(0, 1));
      s_len[d][i*BL +: BL]   = pend[d][i] ? BL'(plen[d][i]) : BL'($urandom_range(0, 15));
      s_addr[d][i*AW +: AW]  = pend[d][i] ? paddr[d][i] : $urandom;
      s_wdata[d][i*DW +: DW] = $urandom;
    end
    m_rdy[d]   = ($urandom_range(0, 3) != 0);
    m_rdata[d] = $urandom;
    if (force_orphan) m_rdval[d] = 1'b1;
    else m_rdval[d] = (rq_n[d] > 0) && ($urandom_range(0, 7) < (rdv_hot ? 6 : 1));
  endtask

  task automatic predict(input int d);
    int o;
    e_val[d] = 1'b0; e_wr[d] = 1'b0; e_len[d] = '0; e_addr[d] = '0;
    e_wdata[d] = '0; e_rdy[d] = '0; e_rdval[d] = '0;
    o = owner[d];
    if (o >= 0) begin
      e_val[d]   = s_val[d][o];
      e_wr[d]    = s_wr[d][o];
      e_len[d]   = s_len[d][o*BL +: BL];
      e_addr[d]  = s_addr[d][o*AW +: AW];
      e_wdata[d] = s_wdata[d][o*DW +: DW];
      if (m_rdy[d]) e_rdy[d][o] = 1'b1;
    end
    if (m_rdval[d] && rq_n[d] > 0) e_rdval[d][rq_p[d][0]] = 1'b1;
  endtask

  task automatic check_dut(input int d);
    chk($sformatf("d%0d m_val", d), 128'(m_val[d]), 128'(e_val[d]));
    chk($sformatf("d%0d m_wr", d), 128'(m_wr[d]), 128'(e_wr[d]));
    chk($sformatf("d%0d m_len", d), 128'(m_len[d]), 128'(e_len[d]));
    chk($sformatf("d%0d m_addr", d), 128'(m_addr[d]), 128'(e_addr[d]));
    chk($sformatf("d%0d m_wdata", d), 128'(m_wdata[d]), 128'(e_wdata[d]));
    chk($sformatf("d%0d s_rdy", d), 128'(s_rdy[d]), 128'(e_rdy[d]));
    chk($sformatf("d%0d s_rdval", d), 128'(s_rdval[d]), 128'(e_rdval[d]));
    chk($sformatf("d%0d s_rdata", d), 128'(s_rdata[d]), 128'({N{m_rdata[d]}}));
    chk($sformatf("d%0d err_orphan", d), 128'(err_orphan[d]), 128'(orphan[d]));
  endtask

  task automatic update(input int d);
    int best, i, o, eff;
    best = -1;
    if (owner[d] < 0) begin
      for (int k = 0; k < N; k++) begin
        i = (mode[d] == 0) ? k : (rr_last[d] + 1 + k) % N;
        if (best < 0 && s_val[d][i] && (s_wr[d][i] || rq_n[d] < depth[d])) best = i;
      end
    end
    if (m_rdval[d]) begin
      if (rq_n[d] > 0) begin
        beats_done[d]++;
        if (beats_done[d] == rq_l[d][0]) begin
          for (int j = 0; j < rq_n[d] - 1; j++) begin
            rq_p[d][j] = rq_p[d][j+1];
            rq_l[d][j] = rq_l[d][j+1];
          end
          rq_n[d]--;
          beats_done[d] = 0;
        end
      end else begin
        orphan[d] = 1'b1;
      end
    end
    for (int p = 0; p < N; p++) begin
      if (e_rdy[d][p] && s_val[d][p]) begin
        if (!pwr[d][p]) pend[d][p] = 1'b0;
        else begin
          pbeats[d][p]++;
          if (pbeats[d][p] == ((plen[d][p] == 0) ? 1 : plen[d][p])) pend[d][p] = 1'b0;
        end
      end
    end
    if (owner[d] >= 0 && e_val[d] && m_rdy[d]) begin
      o   = owner[d];
      eff = int'(s_len[d][o*BL +: BL]);
      if (eff == 0) eff = 1;
      if (beats_left[d] < 0) begin
        if (!s_wr[d][o]) begin
          rq_p[d][rq_n[d]] = o;
          rq_l[d][rq_n[d]] = eff;
          rq_n[d]++;
          owner[d] = -1;
        end else begin
          beats_left[d] = eff - 1;
        end
      end else begin
        beats_left[d]--;
      end
      if (owner[d] >= 0 && beats_left[d] == 0) begin
        owner[d] = -1;
        beats_left[d] = -1;
      end
    end
    if (best >= 0) begin
      owner[d]      = best;
      rr_last[d]    = best;
      beats_left[d] = -1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    m_rdval[0] = 1'b1;
    m_rdval[1] = 1'b1;
    #1;
    reset_check("midrst");
    @(posedge clk);
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      s_val[d]   = '0;
      m_rdval[d] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    no_new = 1'b0; rdv_hot = 1'b0; force_orphan = 1'b0;
    next_rst = 900;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      s_val[d] = '0; s_wr[d] = '0; s_len[d] = '0; s_addr[d] = '0; s_wdata[d] = '0;
      m_rdy[d] = 1'b1; m_rdata[d] = '0; m_rdval[d] = 1'b1;
    end
    #3;
    reset_check("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_rdval[0] = 1'b0;
    m_rdval[1] = 1'b0;
    rst = 1'b0;

    for (int cyc = 0; cyc < NCYC + 320; cyc++) begin
      no_new       = (cyc >= NCYC);
      rdv_hot      = no_new || ((cyc / 250) % 2 == 0);
      force_orphan = (cyc == NCYC + 300);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        drive(d);
        predict(d);
      end
      #1;
      for (int d = 0; d < 2; d++) check_dut(d);
      @(posedge clk);
      for (int d = 0; d < 2; d++) update(d);
      if (!no_new && cyc > next_rst && owner[1] >= 0 && beats_left[1] > 0) begin
        do_reset();
        next_rst = cyc + 900;
      end
    end

    @(negedge clk);
    #1;
    chk("orphan d0", 128'(err_orphan[0]), 128'(1));
    chk("orphan d1", 128'(err_orphan[1]), 128'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xlib_avalon_bus_arb.md
# xlib_avalon_bus_arb

Unified N-port Avalon-MM burst arbiter: merges read and write traffic from N upstream ports onto one downstream master port. It replaces the separate write/read bus pair with a single arbitration point, with fixed-priority or round-robin arbitration and a parametrised outstanding-read routing FIFO. It sits between DMA/engine clients and the memory controller port.

## Interface
- N, 4: number of upstream ports (2..16)
- DW, 32: data width
- AW, 32: address width
- BL, 4: burst-length field width; beats = len, 1..2^BL-1
- FW, 3: log2 depth of the outstanding-read FIFO (2^FW entries)
- MODE, 1: 0 = fixed priority (port 0 highest), 1 = round-robin

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- s_val  in  N  per-port command/write-beat valid
- s_rdy  out  N  per-port accept
- s_wr  in  N  1 = write, 0 = read
- s_len  in  N*BL  burst length
- s_addr  in  N*AW  burst start address
- s_wdata  in  N*DW  write data
- s_rdata  out  N*DW  read data (m_rdata broadcast)
- s_rdval  out  N  per-port read-data valid
- m_rdy  in  1  downstream accept (inverse waitrequest)
- m_val  out  1  downstream command/write-beat valid
- m_wr  out  1  downstream write
- m_len  out  BL  downstream burst length
- m_addr  out  AW  downstream address
- m_wdata  out  DW  downstream write data
- m_rdata  in  DW  downstream read data
- m_rdval  in  1  downstream read-data valid
- err_orphan  out  1  sticky: m_rdval arrived with FIFO empty

## Operation
- States: IDLE, GRANT, WBURST.
- IDLE: eligible[i] = s_val[i] & (s_wr[i] | !fifo_full). If any eligible, register winner into grant, go to GRANT. MODE 0: lowest eligible index. MODE 1: first eligible index searching from last_grant+1 upward with wrap; last_grant updates on each grant.
- GRANT/WBURST: m_val = s_val[grant]; m_wr/m_len/m_addr/m_wdata muxed from port grant; s_rdy[grant] = m_rdy; all other s_rdy = 0.
- GRANT, read accepted (m_val & m_rdy & !m_wr): push {grant, len} to FIFO, go to IDLE.
- GRANT, write accepted: beat counter = len-1; if len==1, go to IDLE, else go to WBURST.
- WBURST: each accepted beat decrements the counter. The beat accepted when the counter is 1 is the last; then go to IDLE. Grant is held for the whole burst; other ports cannot interleave.
- len==0 is illegal and is treated as 1 beat. A command with len 0 pushes len 1 to the FIFO.
- Read return: s_rdata[i] = m_rdata for all i. s_rdval[head.port] = m_rdval & !fifo_empty. A beat counter loads head.len and decrements per m_rdval. On the last beat, pop.
- m_rdval with FIFO empty: the beat is dropped, err_orphan is set, and it clears only on rst.
- Writes are never blocked by a full FIFO. Reads from a port wait while the FIFO is full.
- A push in GRANT while the FIFO is full cannot occur, because eligibility was checked in IDLE and only pops happen in between. Same-cycle push and pop leaves the count unchanged.

## Timing
- Reset values:
  - outputs: m_val 0, m_wr 0, m_len 0, m_addr 0, m_wdata 0, s_rdy 0, s_rdval 0, err_orphan 0.
  - internal: state IDLE, FIFO empty, last_grant = N-1 (port 0 is first in round-robin), counters 0.
- rst mid-burst or with reads outstanding: abandon immediately and return to IDLE with the FIFO empty. Read data still in flight afterward raises err_orphan.
- Latency: s_val to m_val is 1 cycle (registered grant). Each transaction costs 1 IDLE bubble cycle after completion.
- Command and read-data paths are combinational pass-throughs once granted. s_rdval has 0-cycle latency from m_rdval.
- Maximum outstanding reads: 2^FW. The read path can pop at 1 entry per burst at full m_rdval rate.
- s_val must stay high, with stable addr/len, until accepted. A port dropping s_val in GRANT stalls the bus until it re-asserts.

## Test plan
- Single-port read, then write: port 2 reads len 4 at addr 0x100, then writes len 2.
  - m_val 1 cycle after s_val.
  - 4 m_rdval beats produce s_rdval[2] only.
  - Write holds grant for 2 accepted beats, then IDLE.
- Round-robin fairness (MODE 1): all 4 ports continuously request len-1 writes.
  - Grant order is 0,1,2,3,0,… with 2 cycles per grant.
  - With MODE 0, port 0 wins every time.
- FIFO full: FW=1 with m_rdval held off; issue 3 reads from ports 0, 1, 2.
  - Only 2 are accepted; port 2 waits.
  - A write from port 3 is still granted.
  - After the first read returns, port 2 is granted.
- Out-of-order clients, in-order return: reads port 1 len 3, then port 0 len 1.
  - s_rdval[1] pulses 3 beats, then s_rdval[0] pulses 1 beat.
  - m_rdval stalls between beats are tolerated.
- Boundaries:
  - len 0 write completes in 1 beat.
  - m_rdval with empty FIFO sets err_orphan to 1.
  - rst asserted mid-WBURST: all outputs return to reset values asynchronously.
